// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM for the multi-cycle RV32I core.
// Sequences the shared ALU, the unified memory and the PC/IR/OldPC/ALUOut
// registers. Each instruction takes 3-5 states plus memory wait cycles.
// Also keeps a retired-instruction counter and a sticky illegal flag.
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [6:0]       OP,
  input  logic [2:0]       funct3,
  input  logic             funct7,
  input  logic             Zero,
  input  logic             sign,
  input  logic             MemReady,
  output logic             PCWrite,
  output logic             AdrSrc,
  output logic             IRWrite,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ImmSrc,
  output logic [2:0]       ALUControl,
  output logic             Illegal,
  output logic [CNT_W-1:0] InstrRetired,
  output logic [3:0]       State
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_ILLEGAL  = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  state_t state;
  state_t next_state;
  state_t decode_target;
  logic   is_store;
  logic   branch_taken;
  logic   retire;
  logic   illegal_q;

  // funct3 to ALU operation; sub selects SUB for funct3=000 (R-type only)
  function automatic logic [2:0] alu_map(input logic [2:0] f3, input logic sub);
    logic [2:0] op;
    op = ALU_ADD;
    case (f3)
      3'b000:  op = sub ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  assign is_store = (OP == OP_STORE);

  // Branch condition from the SUB result flags: beq/bne use Zero, blt/bge use sign
  always_comb begin
    branch_taken = 1'b0;
    case ({funct3[2], funct3[0]})
      2'b00:   branch_taken = Zero;
      2'b01:   branch_taken = ~Zero;
      2'b10:   branch_taken = sign;
      2'b11:   branch_taken = ~sign;
      default: branch_taken = 1'b0;
    endcase
  end

  // Instruction classification done in DECODE; unsupported encodings trap to ILLEGAL
  always_comb begin
    decode_target = S_ILLEGAL;
    case (OP)
      OP_LOAD, OP_STORE: decode_target = S_MEMADR;
      OP_RTYPE:          decode_target = (funct3 == 3'b011) ? S_ILLEGAL : S_EXECR;
      OP_ITYPE:          decode_target = (funct3 == 3'b011) ? S_ILLEGAL : S_EXECI;
      OP_BRANCH:         decode_target = funct3[1] ? S_ILLEGAL : S_BRANCH;
      default:           decode_target = S_ILLEGAL;
    endcase
  end

  // State register; reset aborts whatever state is in progress
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= S_FETCH;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; memory states wait on MemReady, ILLEGAL is a trap
  always_comb begin
    next_state = state;
    case (state)
      S_FETCH:    if (MemReady) next_state = S_DECODE;
      S_DECODE:   next_state = decode_target;
      S_MEMADR:   next_state = is_store ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (MemReady) next_state = S_MEMWB;
      S_MEMWB:    next_state = S_FETCH;
      S_MEMWRITE: if (MemReady) next_state = S_FETCH;
      S_EXECR:    next_state = S_ALUWB;
      S_EXECI:    next_state = S_ALUWB;
      S_ALUWB:    next_state = S_FETCH;
      S_BRANCH:   next_state = S_FETCH;
      S_ILLEGAL:  next_state = S_ILLEGAL;
      default:    next_state = S_FETCH;
    endcase
  end

  // Datapath control decode from the current state (strobes default to 0)
  always_comb begin
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    IRWrite    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ImmSrc     = 2'b00;
    ALUControl = ALU_ADD;
    case (state)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = MemReady;
        PCWrite   = MemReady;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        ImmSrc  = 2'b10;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ImmSrc  = is_store ? 2'b01 : 2'b00;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA    = 2'b10;
        ALUControl = alu_map(funct3, funct7);
      end
      S_EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = alu_map(funct3, 1'b0);
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUControl = ALU_SUB;
        PCWrite    = branch_taken;
      end
      default: begin
        PCWrite = 1'b0;
      end
    endcase
  end

  assign retire = (state == S_MEMWB) || (state == S_ALUWB) || (state == S_BRANCH) ||
                  ((state == S_MEMWRITE) && MemReady);

  // Retired-instruction counter; wraps naturally at 2^CNT_W
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      InstrRetired <= '0;
    end else if (retire) begin
      InstrRetired <= InstrRetired + CNT_W'(1);
    end
  end

  // Sticky illegal flag, raised together with the entry into ILLEGAL
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      illegal_q <= 1'b0;
    end else if (next_state == S_ILLEGAL) begin
      illegal_q <= 1'b1;
    end
  end

  assign Illegal = illegal_q;
  assign State   = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: randomized self-checking bench for multicycle_ctrl.
// Expected state traces, strobe counts and the retire count come from an
// instruction-level model (per-class latency and wait cycles).
module tb_multicycle_ctrl;

  localparam int CNT_W = 4;
  localparam int K_LW = 0, K_SW = 1, K_R = 2, K_I = 3, K_BR = 4;

  logic             CLK = 1'b0;
  logic             RST;
  logic [6:0]       OP;
  logic [2:0]       funct3;
  logic             funct7, Zero, sign, MemReady;
  logic             PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, Illegal;
  logic [1:0]       ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0]       ALUControl;
  logic [CNT_W-1:0] InstrRetired;
  logic [3:0]       State;

  int n_cmp = 0;
  int n_fail = 0;
  int exp_count = 0;

  int         exp_trace[$];
  int         obs_trace[$];
  logic [2:0] obs_alu;
  logic [1:0] obs_imm;
  logic       obs_pcw;
  int         obs_regw, obs_memw, obs_misc;
  bit         obs_timeout;

  logic [2:0] alu_f3s[7] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b110, 3'b111};
  logic [2:0] br_f3s[4]  = '{3'b000, 3'b001, 3'b100, 3'b101};

  multicycle_ctrl #(.CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .OP(OP), .funct3(funct3), .funct7(funct7),
    .Zero(Zero), .sign(sign), .MemReady(MemReady),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .ALUControl(ALUControl), .Illegal(Illegal),
    .InstrRetired(InstrRetired), .State(State)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [6:0] op_of(input int kind);
    case (kind)
      K_LW:    return 7'b0000011;
      K_SW:    return 7'b0100011;
      K_R:     return 7'b0110011;
      K_I:     return 7'b0010011;
      default: return 7'b1100011;
    endcase
  endfunction

  function automatic logic [2:0] exp_alu(input int kind, input logic [2:0] f3, input logic f7);
    case (f3)
      3'b000:  return (kind == K_R && f7) ? 3'b001 : 3'b000;
      3'b001:  return 3'b110;
      3'b010:  return 3'b101;
      3'b100:  return 3'b100;
      3'b101:  return 3'b111;
      3'b110:  return 3'b011;
      default: return 3'b010;
    endcase
  endfunction

  function automatic logic exp_taken(input logic [2:0] f3, input logic z, input logic s);
    case (f3)
      3'b000:  return z;
      3'b001:  return !z;
      3'b100:  return s;
      default: return !s;
    endcase
  endfunction

  // Expected state trace of one instruction, including fetch and memory waits
  task automatic model_trace(input int kind, input int fw, input int mw);
    exp_trace.delete();
    repeat (fw + 1) exp_trace.push_back(0);
    exp_trace.push_back(1);
    case (kind)
      K_LW: begin
        exp_trace.push_back(2);
        repeat (mw + 1) exp_trace.push_back(3);
        exp_trace.push_back(4);
      end
      K_SW: begin
        exp_trace.push_back(2);
        repeat (mw + 1) exp_trace.push_back(5);
      end
      K_R:     begin exp_trace.push_back(6); exp_trace.push_back(8); end
      K_I:     begin exp_trace.push_back(7); exp_trace.push_back(8); end
      default: exp_trace.push_back(9);
    endcase
  endtask

  function automatic int trace_diff();
    int n;
    n = (obs_trace.size() < exp_trace.size()) ? obs_trace.size() : exp_trace.size();
    for (int i = 0; i < n; i++) if (obs_trace[i] != exp_trace[i]) return i;
    if (obs_trace.size() != exp_trace.size()) return n;
    return -1;
  endfunction

  // Drives one instruction from FETCH back to FETCH, recording observations
  task automatic run_instr(input int kind, input logic [2:0] f3, input logic f7,
                           input logic z, input logic s, input int fw, input int mw);
    int  cyc, waitc, prev, st, lim;
    bit  left;
    OP = op_of(kind); funct3 = f3; funct7 = f7; Zero = z; sign = s;
    obs_trace.delete();
    obs_alu = 3'bxxx; obs_imm = 2'bxx; obs_pcw = 1'bx;
    obs_regw = 0; obs_memw = 0; obs_misc = 0; obs_timeout = 0;
    cyc = 0; waitc = 0; prev = -1; left = 0;
    forever begin
      st = int'(State);
      if (left && st == 0) break;
      if (cyc >= 40) begin obs_timeout = 1; break; end
      if (st != 0) left = 1;
      if (st != prev) waitc = 0;
      if (st == 0 || st == 3 || st == 5) begin
        lim = (st == 0) ? fw : mw;
        MemReady = (waitc >= lim);
        waitc++;
      end else begin
        MemReady = 1'($urandom_range(0, 1));
      end
      #1;
      obs_trace.push_back(st);
      if (RegWrite) obs_regw++;
      if (MemWrite) obs_memw++;
      if (st == 6 || st == 7) obs_alu = ALUControl;
      if (st == 9) obs_pcw = PCWrite;
      if (st == 2) obs_imm = ImmSrc;
      if (RegWrite !== (st == 4 || st == 8)) obs_misc++;
      if (MemWrite !== (st == 5)) obs_misc++;
      case (st)
        0: if (AdrSrc !== 0 || ALUSrcA !== 0 || ALUSrcB !== 2 || ALUControl !== 0 ||
               ResultSrc !== 2 || IRWrite !== MemReady || PCWrite !== MemReady) obs_misc++;
        1: if (ALUSrcA !== 1 || ALUSrcB !== 1 || ImmSrc !== 2 || ALUControl !== 0 ||
               IRWrite !== 0 || PCWrite !== 0) obs_misc++;
        2: if (ALUSrcA !== 2 || ALUSrcB !== 1 || ALUControl !== 0) obs_misc++;
        3: if (AdrSrc !== 1 || ResultSrc !== 0) obs_misc++;
        4: if (ResultSrc !== 1) obs_misc++;
        5: if (AdrSrc !== 1 || ResultSrc !== 0) obs_misc++;
        6: if (ALUSrcA !== 2 || ALUSrcB !== 0) obs_misc++;
        7: if (ALUSrcA !== 2 || ALUSrcB !== 1 || ImmSrc !== 0) obs_misc++;
        8: if (ResultSrc !== 0) obs_misc++;
        9: if (ALUSrcA !== 2 || ALUSrcB !== 0 || ALUControl !== 1 || ResultSrc !== 0) obs_misc++;
        default: obs_misc++;
      endcase
      prev = st;
      cyc++;
      @(negedge CLK);
    end
    if (!obs_timeout) exp_count = (exp_count + 1) % (1 << CNT_W);
  endtask

  task automatic do_reset();
    RST = 1'b0;
    MemReady = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    exp_count = 0;
  endtask

  task automatic test_reset();
    RST = 1'b0; MemReady = 1'b1; OP = '0; funct3 = '0; funct7 = 0; Zero = 0; sign = 0;
    repeat (3) @(negedge CLK);
    #1;
    n_cmp++;
    if (State !== 4'd0) begin n_fail++; $display("[TB] FAIL reset_state: got %0d want 0", State); end
    n_cmp++;
    if (InstrRetired !== '0 || Illegal !== 1'b0) begin
      n_fail++; $display("[TB] FAIL reset_regs: count=%0d illegal=%b want 0/0", InstrRetired, Illegal);
    end
    n_cmp++;
    if ({IRWrite, PCWrite, MemWrite, RegWrite} !== 4'b1100) begin
      n_fail++; $display("[TB] FAIL reset_strobes: got %b want 1100", {IRWrite, PCWrite, MemWrite, RegWrite});
    end
    n_cmp++;
    if ({AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl} !== {1'b0, 2'b00, 2'b10, 2'b10, 3'b000}) begin
      n_fail++; $display("[TB] FAIL reset_fetch_ctrl: got %b want 0001010000",
                         {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl});
    end
    @(negedge CLK);
    RST = 1'b1;
    exp_count = 0;
  endtask

  task automatic test_add();
    model_trace(K_R, 0, 0);
    run_instr(K_R, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0);
    n_cmp++;
    if (trace_diff() != -1) begin
      n_fail++; $display("[TB] FAIL add_trace: len %0d diff@%0d want len %0d", obs_trace.size(), trace_diff(), exp_trace.size());
    end
    n_cmp++;
    if (obs_alu !== 3'b000) begin n_fail++; $display("[TB] FAIL add_alu: got %b want 000", obs_alu); end
    n_cmp++;
    if (obs_regw !== 1 || obs_misc !== 0) begin
      n_fail++; $display("[TB] FAIL add_ctrl: regw=%0d misc=%0d want 1/0", obs_regw, obs_misc);
    end
    n_cmp++;
    if (InstrRetired !== CNT_W'(1)) begin n_fail++; $display("[TB] FAIL add_count: got %0d want 1", InstrRetired); end
  endtask

  task automatic test_lw_wait();
    model_trace(K_LW, 0, 3);
    run_instr(K_LW, 3'b010, 1'b0, 1'b0, 1'b0, 0, 3);
    n_cmp++;
    if (trace_diff() != -1) begin
      n_fail++; $display("[TB] FAIL lw_trace: len %0d diff@%0d want len %0d", obs_trace.size(), trace_diff(), exp_trace.size());
    end
    n_cmp++;
    if (obs_regw !== 1 || obs_misc !== 0 || obs_imm !== 2'b00) begin
      n_fail++; $display("[TB] FAIL lw_ctrl: regw=%0d misc=%0d imm=%b want 1/0/00", obs_regw, obs_misc, obs_imm);
    end
    n_cmp++;
    if (InstrRetired !== CNT_W'(exp_count)) begin
      n_fail++; $display("[TB] FAIL lw_count: got %0d want %0d", InstrRetired, exp_count);
    end
  endtask

  task automatic test_sw_branch();
    model_trace(K_SW, 0, 2);
    run_instr(K_SW, 3'b010, 1'b0, 1'b0, 1'b0, 0, 2);
    n_cmp++;
    if (trace_diff() != -1 || obs_memw !== 3 || obs_imm !== 2'b01) begin
      n_fail++; $display("[TB] FAIL sw_wait: diff@%0d memw=%0d imm=%b want -1/3/01", trace_diff(), obs_memw, obs_imm);
    end
    run_instr(K_BR, 3'b000, 1'b0, 1'b1, 1'b0, 0, 0);
    n_cmp++;
    if (obs_pcw !== 1'b1) begin n_fail++; $display("[TB] FAIL beq_taken: got %b want 1", obs_pcw); end
    run_instr(K_BR, 3'b001, 1'b0, 1'b1, 1'b0, 0, 0);
    n_cmp++;
    if (obs_pcw !== 1'b0) begin n_fail++; $display("[TB] FAIL bne_not_taken: got %b want 0", obs_pcw); end
    n_cmp++;
    if (InstrRetired !== CNT_W'(exp_count)) begin
      n_fail++; $display("[TB] FAIL sw_br_count: got %0d want %0d", InstrRetired, exp_count);
    end
  endtask

  task automatic test_random();
    int kind, fw, mw, exp_regw, exp_memw;
    logic [2:0] f3;
    logic f7, z, s;
    for (int i = 0; i < 30; i++) begin
      kind = $urandom_range(0, 4);
      fw = $urandom_range(0, 2);
      mw = $urandom_range(0, 3);
      f7 = 1'($urandom_range(0, 1));
      z = 1'($urandom_range(0, 1));
      s = 1'($urandom_range(0, 1));
      if (kind == K_LW || kind == K_SW) f3 = 3'b010;
      else if (kind == K_BR) f3 = br_f3s[$urandom_range(0, 3)];
      else f3 = alu_f3s[$urandom_range(0, 6)];
      model_trace(kind, fw, mw);
      exp_regw = (kind == K_LW || kind == K_R || kind == K_I) ? 1 : 0;
      exp_memw = (kind == K_SW) ? mw + 1 : 0;
      run_instr(kind, f3, f7, z, s, fw, mw);
      n_cmp++;
      if (trace_diff() != -1) begin
        n_fail++; $display("[TB] FAIL rand_trace[%0d]: kind=%0d len %0d diff@%0d want len %0d",
                           i, kind, obs_trace.size(), trace_diff(), exp_trace.size());
      end
      n_cmp++;
      if (obs_misc !== 0) begin n_fail++; $display("[TB] FAIL rand_ctrl[%0d]: kind=%0d bad=%0d want 0", i, kind, obs_misc); end
      n_cmp++;
      if (obs_regw !== exp_regw || obs_memw !== exp_memw) begin
        n_fail++; $display("[TB] FAIL rand_strobes[%0d]: regw=%0d memw=%0d want %0d/%0d", i, obs_regw, obs_memw, exp_regw, exp_memw);
      end
      n_cmp++;
      if (kind == K_R || kind == K_I) begin
        if (obs_alu !== exp_alu(kind, f3, f7)) begin
          n_fail++; $display("[TB] FAIL rand_alu[%0d]: f3=%b f7=%b got %b want %b", i, f3, f7, obs_alu, exp_alu(kind, f3, f7));
        end
      end else if (kind == K_BR) begin
        if (obs_pcw !== exp_taken(f3, z, s)) begin
          n_fail++; $display("[TB] FAIL rand_branch[%0d]: f3=%b z=%b s=%b got %b want %b", i, f3, z, s, obs_pcw, exp_taken(f3, z, s));
        end
      end else begin
        if (obs_imm !== ((kind == K_SW) ? 2'b01 : 2'b00)) begin
          n_fail++; $display("[TB] FAIL rand_imm[%0d]: kind=%0d got %b", i, kind, obs_imm);
        end
      end
      n_cmp++;
      if (InstrRetired !== CNT_W'(exp_count)) begin
        n_fail++; $display("[TB] FAIL rand_count[%0d]: got %0d want %0d", i, InstrRetired, exp_count);
      end
    end
  endtask

  task automatic test_counter_wrap();
    do_reset();
    for (int i = 0; i < 15; i++) run_instr(K_I, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0);
    n_cmp++;
    if (InstrRetired !== 4'd15) begin n_fail++; $display("[TB] FAIL wrap_max: got %0d want 15", InstrRetired); end
    run_instr(K_R, 3'b111, 1'b0, 1'b0, 1'b0, 0, 0);
    n_cmp++;
    if (InstrRetired !== 4'd0) begin n_fail++; $display("[TB] FAIL wrap_zero: got %0d want 0", InstrRetired); end
  endtask

  task automatic test_illegal();
    logic [6:0] ops[4] = '{7'b1111111, 7'b0110011, 7'b1100011, 7'b0010011};
    logic [2:0] f3s[4] = '{3'b000, 3'b011, 3'b110, 3'b011};
    int cyc, bad;
    for (int k = 0; k < 4; k++) begin
      do_reset();
      OP = ops[k]; funct3 = f3s[k]; funct7 = 0; MemReady = 1'b1;
      cyc = 0;
      while (State !== 4'd15 && cyc < 10) begin @(negedge CLK); cyc++; end
      #1;
      n_cmp++;
      if (State !== 4'd15 || Illegal !== 1'b1 || cyc !== 2) begin
        n_fail++; $display("[TB] FAIL illegal_entry[%0d]: state=%0d illegal=%b cycles=%0d want 15/1/2", k, State, Illegal, cyc);
      end
      bad = 0;
      for (int c = 0; c < 6; c++) begin
        @(negedge CLK);
        MemReady = 1'($urandom_range(0, 1));
        #1;
        if (State !== 4'd15 || Illegal !== 1'b1 || {IRWrite, PCWrite, MemWrite, RegWrite} !== 4'b0000) bad++;
      end
      n_cmp++;
      if (bad !== 0 || InstrRetired !== '0) begin
        n_fail++; $display("[TB] FAIL illegal_hold[%0d]: bad=%0d count=%0d want 0/0", k, bad, InstrRetired);
      end
      @(negedge CLK);
      do_reset();
      #1;
      n_cmp++;
      if (State !== 4'd0 || Illegal !== 1'b0) begin
        n_fail++; $display("[TB] FAIL illegal_clear[%0d]: state=%0d illegal=%b want 0/0", k, State, Illegal);
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_reset_memwrite();
    int cyc;
    do_reset();
    run_instr(K_R, 3'b000, 1'b1, 1'b0, 1'b0, 0, 0);
    OP = 7'b0100011; funct3 = 3'b010;
    cyc = 0;
    while (State !== 4'd5 && cyc < 10) begin
      MemReady = (State == 4'd0);
      @(negedge CLK);
      cyc++;
    end
    MemReady = 1'b0;
    #1;
    n_cmp++;
    if (MemWrite !== 1'b1 || State !== 4'd5) begin
      n_fail++; $display("[TB] FAIL rst_mw_pre: state=%0d memwrite=%b want 5/1", State, MemWrite);
    end
    #2;
    RST = 1'b0;
    #1;
    n_cmp++;
    if (MemWrite !== 1'b0 || State !== 4'd0 || InstrRetired !== '0) begin
      n_fail++; $display("[TB] FAIL rst_mw_drop: memwrite=%b state=%0d count=%0d want 0/0/0", MemWrite, State, InstrRetired);
    end
    @(negedge CLK);
    RST = 1'b1;
    exp_count = 0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw_wait();
    test_sw_branch();
    test_random();
    test_counter_wrap();
    test_illegal();
    test_reset_memwrite();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
